schoolrisc_cpu_vc: RTL and testbench
====================================

Name:
schoolrisc_cpu_vc

Overview:
- Single-cycle RV32I-subset CPU (schoolRISCV class) with a debug register-read port and a video-control-unit (VCU) register interface.
- Fetches from an external combinational instruction ROM: word address out, instruction back in the same cycle.
- Custom instructions drive the VCU control and data registers and read a 32-bit VCU status input.
- Sits between the program ROM and the display/timer logic at chip top.

Parameters:
- None.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- regAddr  in  5  debug read address; 0 selects PC, 1..31 select x1..x31.
- regData  out  32  debug read data, combinational from regAddr.
- imAddr  out  32  instruction word address = PC >> 2.
- imData  in  32  instruction at imAddr, same cycle.
- vcu_reg_control  out  32  VCU control register.
- vcu_reg_control_we  out  1  one-cycle strobe: new vcu_reg_control value.
- vcu_reg_wdata  out  32  VCU write-data register (holds last written value).
- vcu_reg_wdata_we  out  1  one-cycle strobe: new vcu_reg_wdata value.
- vcu_reg_rdata  in  32  VCU status/read data.

Behaviour:
- Reset (async, rst_n=0): clears PC, x1..x31, vcu_reg_control, vcu_reg_wdata and both strobes to 0. Reset mid-program aborts the current instruction. First fetch after release is from word 0.
- x0 always reads 0; writes to x0 are discarded.
- One instruction per clock. Register and PC update at the rising edge. Register file reads are combinational.
- Default next PC is PC+4 (32-bit wrap).
- Supported instructions:
  - R-type: add, sub, or, srl (shift amount = rs2[4:0]), sltu.
  - I-type: addi (sign-extended 12-bit immediate).
  - U-type: lui.
  - B-type: beq, bne.
- Branch taken: PC <= PC + sign-extended B-immediate. Not taken: PC+4.
- All arithmetic is 32-bit modulo, with no overflow trap.
- Any other encoding executes as a NOP: PC+4, no register or VCU write.
- Custom-0 opcode 7'b0001011, I-type layout, immediate ignored, selected by funct3:
  - 000 vcuwc: vcu_reg_control <= rs1; vcu_reg_control_we <= 1 for the next cycle.
  - 001 vcuwd: vcu_reg_wdata <= rs1; vcu_reg_wdata_we <= 1 for the next cycle.
  - 010 vcurd: rd <= vcu_reg_rdata sampled at this edge.
  - Other funct3 values: NOP.
- Strobes are registered and asserted exactly one cycle per write instruction.
  - Back-to-back writes hold the strobe high for consecutive cycles, with the data updating each cycle.
  - Strobes deassert on any cycle without a matching write.
- vcu_reg_control and vcu_reg_wdata hold their value until the next write or reset.
- regData: regAddr==0 returns the current PC. Otherwise it returns the register content before this edge's write.

Decomposition:
- Package sr_cpu_pkg holds:
  - opcode constants (OP, OP_IMM, LUI, BRANCH, CUSTOM0);
  - funct3/funct7 constants;
  - ALU-operation enum;
  - VCU funct3 codes.
- One natural sub-module: sr_regfile. It has 32x32 entries, two combinational read ports, a third debug read port, one synchronous write port, async active-low reset, and x0 hardwired to 0.
- Decode, ALU and PC logic stay in the top.
- The instruction ROM is external.

Test Plan:
- Reset: hold rst_n=0, then release -> imAddr=0, regData(regAddr=0)=0, vcu_reg_control=0, vcu_reg_wdata=0, both strobes 0.
- Arithmetic: addi x10,x0,5; addi x11,x0,3; sub x10,x10,x11; lui x12,0x12345 -> x10 (regAddr=10) = 2, x12 = 0x12345000; PC reads 16 after 4 cycles.
- Branch loop: addi x10,x10,1; bne x10,x11,-4 with x11=3 -> loop exits after 3 iterations, x10=3, PC continues at the next word.
- VCU write: addi x30,x0,0x5A; vcuwd x30 -> next cycle vcu_reg_wdata=0x5A and vcu_reg_wdata_we=1 for exactly one cycle. vcuwc with x30 -> vcu_reg_control=0x5A and vcu_reg_control_we pulses once.
- VCU poll: loop vcurd x5; beq x5,x0,-4 with vcu_reg_rdata=0 for 10 cycles, then 1 -> PC stays in the loop, then exits; x5=1.
- Corner cases:
  - addi x0,x0,7 -> regData(0 select of x0) reads 0.
  - Illegal opcode 0xFFFFFFFF -> PC+4, no writes.
  - rst_n pulsed low mid-loop -> PC=0 and outputs cleared immediately.

Source files
------------

// File: rtl/sr_cpu_pkg.sv
// ============================================================================
// sr_cpu_pkg : opcode, funct and ALU definitions for schoolrisc_cpu_vc
// Rev 1.0
// ============================================================================
`default_nettype none

package sr_cpu_pkg;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [2:0] F3_ADD_SUB  = 3'b000;
  localparam logic [2:0] F3_OR       = 3'b110;
  localparam logic [2:0] F3_SRL      = 3'b101;
  localparam logic [2:0] F3_SLTU     = 3'b011;
  localparam logic [2:0] F3_BEQ      = 3'b000;
  localparam logic [2:0] F3_BNE      = 3'b001;

  localparam logic [6:0] F7_BASE     = 7'b0000000;
  localparam logic [6:0] F7_SUB      = 7'b0100000;

  localparam logic [2:0] F3_VCUWC    = 3'b000;
  localparam logic [2:0] F3_VCUWD    = 3'b001;
  localparam logic [2:0] F3_VCURD    = 3'b010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_OR,
    ALU_SRL,
    ALU_SLTU
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/sr_regfile.sv
// ============================================================================
// sr_regfile : 32x32 register file, two read ports, debug read, one write
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  output logic [31:0] rd1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd3,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] rf_q [0:31];
  logic [31:0] rf_d [0:31];

  // Entry 0 is forced to zero every cycle so x0 can never hold a value.
  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[wa] = wd;
    rf_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign rd1 = rf_q[ra1];
  assign rd2 = rf_q[ra2];
  assign rd3 = rf_q[ra3];

endmodule

`default_nettype wire

// File: rtl/schoolrisc_cpu_vc.sv
// ============================================================================
// schoolrisc_cpu_vc : single-cycle RV32I-subset CPU with VCU register access
// Rev 1.0
// ============================================================================
`default_nettype none

module schoolrisc_cpu_vc
  import sr_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  regAddr,
  output logic [31:0] regData,
  output logic [31:0] imAddr,
  input  logic [31:0] imData,
  output logic [31:0] vcu_reg_control,
  output logic        vcu_reg_control_we,
  output logic [31:0] vcu_reg_wdata,
  output logic        vcu_reg_wdata_we,
  input  logic [31:0] vcu_reg_rdata
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] vcu_ctrl_q, vcu_ctrl_d, vcu_wdata_q, vcu_wdata_d;
  logic        ctrl_we_q, ctrl_we_d, wdata_we_q, wdata_we_d;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_u, imm_b;
  logic [31:0] rs1_data, rs2_data, dbg_data;

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_res, rf_wd;
  logic        rf_we, br_taken, is_vcuwc, is_vcuwd;

  assign opcode = imData[6:0];
  assign rd     = imData[11:7];
  assign funct3 = imData[14:12];
  assign rs1    = imData[19:15];
  assign rs2    = imData[24:20];
  assign funct7 = imData[31:25];
  assign imm_i  = {{20{imData[31]}}, imData[31:20]};
  assign imm_u  = {imData[31:12], 12'b0};
  assign imm_b  = {{19{imData[31]}}, imData[31], imData[7], imData[30:25], imData[11:8], 1'b0};

  sr_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .rd1   (rs1_data),
    .ra2   (rs2),
    .rd2   (rs2_data),
    .ra3   (regAddr),
    .rd3   (dbg_data),
    .we    (rf_we),
    .wa    (rd),
    .wd    (rf_wd)
  );

  always_comb begin
    alu_res = rs1_data + alu_b;
    case (alu_op)
      ALU_SUB:  alu_res = rs1_data - alu_b;
      ALU_OR:   alu_res = rs1_data | alu_b;
      ALU_SRL:  alu_res = rs1_data >> alu_b[4:0];
      ALU_SLTU: alu_res = {31'b0, (rs1_data < alu_b)};
      default:  alu_res = rs1_data + alu_b;
    endcase
  end

  // Unrecognised encodings fall through with all write enables low (NOP).
  always_comb begin
    alu_op   = ALU_ADD;
    alu_b    = rs2_data;
    rf_we    = 1'b0;
    rf_wd    = alu_res;
    br_taken = 1'b0;
    is_vcuwc = 1'b0;
    is_vcuwd = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_SUB && funct3 == F3_ADD_SUB) begin
          alu_op = ALU_SUB;
          rf_we  = 1'b1;
        end else if (funct7 == F7_BASE) begin
          rf_we = 1'b1;
          case (funct3)
            F3_ADD_SUB: alu_op = ALU_ADD;
            F3_OR:      alu_op = ALU_OR;
            F3_SRL:     alu_op = ALU_SRL;
            F3_SLTU:    alu_op = ALU_SLTU;
            default:    rf_we  = 1'b0;
          endcase
        end
      end
      OPC_OP_IMM: begin
        alu_b = imm_i;
        rf_we = (funct3 == F3_ADD_SUB);
      end
      OPC_LUI: begin
        rf_wd = imm_u;
        rf_we = 1'b1;
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ) br_taken = (rs1_data == rs2_data);
        if (funct3 == F3_BNE) br_taken = (rs1_data != rs2_data);
      end
      OPC_CUSTOM0: begin
        is_vcuwc = (funct3 == F3_VCUWC);
        is_vcuwd = (funct3 == F3_VCUWD);
        if (funct3 == F3_VCURD) begin
          rf_wd = vcu_reg_rdata;
          rf_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d        = br_taken ? (pc_q + imm_b) : (pc_q + 32'd4);
    vcu_ctrl_d  = is_vcuwc ? rs1_data : vcu_ctrl_q;
    vcu_wdata_d = is_vcuwd ? rs1_data : vcu_wdata_q;
    ctrl_we_d   = is_vcuwc;
    wdata_we_d  = is_vcuwd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      vcu_ctrl_q  <= '0;
      vcu_wdata_q <= '0;
      ctrl_we_q   <= 1'b0;
      wdata_we_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      vcu_ctrl_q  <= vcu_ctrl_d;
      vcu_wdata_q <= vcu_wdata_d;
      ctrl_we_q   <= ctrl_we_d;
      wdata_we_q  <= wdata_we_d;
    end
  end

  assign imAddr             = {2'b00, pc_q[31:2]};
  assign regData            = (regAddr == 5'd0) ? pc_q : dbg_data;
  assign vcu_reg_control    = vcu_ctrl_q;
  assign vcu_reg_control_we = ctrl_we_q;
  assign vcu_reg_wdata      = vcu_wdata_q;
  assign vcu_reg_wdata_we   = wdata_we_q;

endmodule

`default_nettype wire

// File: tb/tb_schoolrisc_cpu_vc.sv
// ============================================================================
// tb_schoolrisc_cpu_vc : self-checking bench for schoolrisc_cpu_vc
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_schoolrisc_cpu_vc;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] LUIO = 7'b0110111;
  localparam logic [6:0] BRO  = 7'b1100011;
  localparam logic [6:0] CU0  = 7'b0001011;

  logic        clk;
  logic        rst_n;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic [31:0] vcu_reg_control;
  logic        vcu_reg_control_we;
  logic [31:0] vcu_reg_wdata;
  logic        vcu_reg_wdata_we;
  logic [31:0] vcu_reg_rdata;

  logic [31:0] rom [0:63];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  addr;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs [15];
  sb_t  sb_q [$];

  schoolrisc_cpu_vc dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .regAddr            (regAddr),
    .regData            (regData),
    .imAddr             (imAddr),
    .imData             (imData),
    .vcu_reg_control    (vcu_reg_control),
    .vcu_reg_control_we (vcu_reg_control_we),
    .vcu_reg_wdata      (vcu_reg_wdata),
    .vcu_reg_wdata_we   (vcu_reg_wdata_we),
    .vcu_reg_rdata      (vcu_reg_rdata)
  );

  assign imData = (imAddr < 32'd64) ? rom[imAddr[5:0]] : 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdx);
    return {f7, r2, r1, f3, rdx, OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rdx,
                                        input logic [6:0] opc);
    return {imm, r1, f3, rdx, opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rdx);
    return {imm, rdx, LUIO};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], BRO};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rd_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
    regAddr = a;
    #1;
    chk(name, regData, exp);
  endtask

  initial begin
    sb_t e;
    rst_n         = 1'b0;
    regAddr       = 5'd0;
    vcu_reg_rdata = 32'h0;
    clear_rom();

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_imaddr", imAddr, 32'd0);
    rd_reg("rst_pc", 5'd0, 32'd0);
    chk("rst_ctrl", vcu_reg_control, 32'd0);
    chk("rst_wdata", vcu_reg_wdata, 32'd0);
    chk("rst_ctrl_we", {31'b0, vcu_reg_control_we}, 32'd0);
    chk("rst_wdata_we", {31'b0, vcu_reg_wdata_we}, 32'd0);

    // ---------------- table-driven single instructions ----------------
    vecs[0]  = '{enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI),        5'd1,  32'd5};
    vecs[1]  = '{enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPI),      5'd2,  32'hFFFF_FFFD};
    vecs[2]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),       5'd3,  32'd2};
    vecs[3]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4),       5'd4,  32'd8};
    vecs[4]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd5),       5'd5,  32'hFFFF_FFFD};
    vecs[5]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd6),       5'd6,  32'h07FF_FFFF};
    vecs[6]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd7),       5'd7,  32'd1};
    vecs[7]  = '{enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd8),       5'd8,  32'd0};
    vecs[8]  = '{enc_u(20'h12345, 5'd9),                       5'd9,  32'h1234_5000};
    vecs[9]  = '{enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI),        5'd1,  32'd5};
    vecs[10] = '{enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd10),      5'd10, 32'd0};
    vecs[11] = '{32'hFFFF_FFFF,                                5'd31, 32'd0};
    vecs[12] = '{enc_i(12'hFFF, 5'd9, 3'b000, 5'd11, OPI),     5'd11, 32'h1234_4FFF};
    vecs[13] = '{enc_r(7'h00, 5'd1, 5'd9, 3'b101, 5'd12),      5'd12, 32'h0091_A280};
    vecs[14] = '{enc_i(12'h000, 5'd0, 3'b010, 5'd13, CU0),     5'd13, 32'hCAFE_0001};

    clear_rom();
    foreach (vecs[k]) rom[k] = vecs[k].instr;
    vcu_reg_rdata = 32'hCAFE_0001;
    do_reset();
    foreach (vecs[k]) begin
      chk($sformatf("vec%0d_fetch", k), imAddr, 32'(k));
      sb_q.push_back('{vecs[k].addr, vecs[k].exp});
      tick();
      e = sb_q.pop_front();
      rd_reg($sformatf("vec%0d_rd", k), e.addr, e.exp);
    end
    rd_reg("vec_pc_final", 5'd0, 32'd60);
    chk("vec_no_vcu_write", vcu_reg_control | vcu_reg_wdata, 32'd0);

    // ---------------- branch loop ----------------
    clear_rom();
    rom[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd11, OPI);
    rom[1] = enc_i(12'd1, 5'd10, 3'b000, 5'd10, OPI);
    rom[2] = enc_b(13'h1FFC, 5'd11, 5'd10, 3'b001);
    rom[3] = enc_i(12'd9, 5'd0, 3'b000, 5'd20, OPI);
    do_reset();
    begin
      int trace [9] = '{0, 1, 2, 1, 2, 1, 2, 3, 4};
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("loop_pc%0d", i), imAddr, 32'(trace[i]));
        if (i < 8) tick();
      end
    end
    rd_reg("loop_x10", 5'd10, 32'd3);
    rd_reg("loop_x20", 5'd20, 32'd9);

    // ---------------- VCU writes ----------------
    clear_rom();
    rom[0] = enc_i(12'h05A, 5'd0, 3'b000, 5'd30, OPI);
    rom[1] = enc_i(12'h000, 5'd30, 3'b001, 5'd0, CU0);
    rom[2] = enc_i(12'h000, 5'd30, 3'b000, 5'd0, CU0);
    rom[3] = 32'h0;
    rom[4] = enc_i(12'h000, 5'd0, 3'b001, 5'd0, CU0);
    rom[5] = enc_i(12'h000, 5'd30, 3'b001, 5'd0, CU0);
    do_reset();
    tick();
    chk("vcu_pre_we", {30'b0, vcu_reg_control_we, vcu_reg_wdata_we}, 32'd0);
    tick();
    chk("vcuwd_data", vcu_reg_wdata, 32'h5A);
    chk("vcuwd_we", {30'b0, vcu_reg_control_we, vcu_reg_wdata_we}, 32'd1);
    tick();
    chk("vcuwc_data", vcu_reg_control, 32'h5A);
    chk("vcuwc_we", {30'b0, vcu_reg_control_we, vcu_reg_wdata_we}, 32'd2);
    chk("vcuwd_hold", vcu_reg_wdata, 32'h5A);
    tick();
    chk("vcu_idle_we", {30'b0, vcu_reg_control_we, vcu_reg_wdata_we}, 32'd0);
    chk("vcuwc_hold", vcu_reg_control, 32'h5A);
    tick();
    chk("b2b1_data", vcu_reg_wdata, 32'h0);
    chk("b2b1_we", {31'b0, vcu_reg_wdata_we}, 32'd1);
    tick();
    chk("b2b2_data", vcu_reg_wdata, 32'h5A);
    chk("b2b2_we", {31'b0, vcu_reg_wdata_we}, 32'd1);
    tick();
    chk("b2b_end_we", {31'b0, vcu_reg_wdata_we}, 32'd0);

    // ---------------- VCU poll ----------------
    clear_rom();
    rom[0] = enc_i(12'h000, 5'd0, 3'b010, 5'd5, CU0);
    rom[1] = enc_b(13'h1FFC, 5'd0, 5'd5, 3'b000);
    rom[2] = enc_i(12'd1, 5'd0, 3'b000, 5'd6, OPI);
    vcu_reg_rdata = 32'h0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("poll_in_loop%0d", i), {31'b0, (imAddr <= 32'd1)}, 32'd1);
    end
    vcu_reg_rdata = 32'd1;
    for (int i = 0; i < 10; i++) begin
      if (imAddr == 32'd2) break;
      tick();
    end
    chk("poll_exit", imAddr, 32'd2);
    tick();
    rd_reg("poll_x5", 5'd5, 32'd1);
    rd_reg("poll_x6", 5'd6, 32'd1);

    // ---------------- asynchronous reset mid-loop ----------------
    clear_rom();
    rom[0] = enc_i(12'h033, 5'd0, 3'b000, 5'd1, OPI);
    rom[1] = enc_i(12'h000, 5'd1, 3'b000, 5'd0, CU0);
    rom[2] = enc_i(12'h000, 5'd1, 3'b001, 5'd0, CU0);
    rom[3] = enc_i(12'h000, 5'd0, 3'b010, 5'd5, CU0);
    rom[4] = enc_b(13'h1FFC, 5'd0, 5'd5, 3'b000);
    vcu_reg_rdata = 32'h0;
    do_reset();
    repeat (8) tick();
    chk("mid_pre_ctrl", vcu_reg_control, 32'h33);
    chk("mid_pre_inloop", {31'b0, (imAddr >= 32'd3)}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_imaddr", imAddr, 32'd0);
    chk("mid_ctrl", vcu_reg_control, 32'd0);
    chk("mid_wdata", vcu_reg_wdata, 32'd0);
    chk("mid_we", {30'b0, vcu_reg_control_we, vcu_reg_wdata_we}, 32'd0);
    rd_reg("mid_pc", 5'd0, 32'd0);
    rd_reg("mid_x1", 5'd1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_restart", imAddr, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
